imem_arbiter: RTL and testbench
===============================

// Module: imem_arbiter
// PURPOSE
//  Shares the single-port instruction memory between the fetch stage (PC-driven read)
//  and a program loader/debug port (read/write). Sequences boot: after reset only the
//  loader is served and fetch is held stalled until the loader signals completion.
//  In RUN, the loader has priority, bounded by an anti-starvation limit for fetch.
//  Sits between the fetch-stage PC/instruction register and the instruction memory.
// PARAMETERS
//  ADDR_W          32  word address width; addresses are word indices, PC steps by 1
//  DATA_W          32  instruction/data word width
//  LOAD_BURST_MAX  8   max consecutive loader grants while fetch waits; range >= 1
// PORTS
//  clk         in   1       clock, rising edge
//  rst         in   1       asynchronous reset, active-low
//  fetch_req   in   1       fetch wants the word at fetch_addr this cycle
//  fetch_addr  in   ADDR_W  fetch word address (the PC)
//  fetch_stall out  1       fetch not granted this cycle; PC and IF/ID regs must hold
//  fetch_rvalid out 1       fetch_rdata valid; one cycle after the fetch grant
//  fetch_rdata out  DATA_W  instruction read for fetch
//  ld_req      in   1       loader access request
//  ld_we       in   1       1 = write, 0 = read
//  ld_addr     in   ADDR_W  loader word address
//  ld_wdata    in   DATA_W  loader write data
//  ld_done     in   1       pulse: program load complete (BOOT -> RUN)
//  ld_gnt      out  1       loader access accepted this cycle (combinational)
//  ld_rvalid   out  1       ld_rdata valid; one cycle after a loader read grant
//  ld_rdata    out  DATA_W  data read for loader
//  mem_en      out  1       memory access strobe (combinational)
//  mem_we      out  1       memory write enable
//  mem_addr    out  ADDR_W  memory word address
//  mem_wdata   out  DATA_W  memory write data
//  mem_rdata   in   DATA_W  synchronous read data, valid 1 cycle after mem_en & !mem_we
// BEHAVIOUR
//  - Reset (rst=0, async): state=BOOT, burst_cnt=0, owner_q=NONE, fetch_rvalid=0,
//    ld_rvalid=0, fetch_rdata=0, ld_rdata=0. Combinational outputs under reset:
//    fetch_stall=1, ld_gnt=0, mem_en=0, mem_we=0, mem_addr/mem_wdata=0.
//  - Exactly one grant per cycle at most; mem_* driven from the granted requester.
//  - BOOT: ld_gnt=ld_req; fetch never granted; fetch_stall=1 regardless of fetch_req.
//    ld_done=1 -> RUN next cycle; a same-cycle ld_req is still granted. ld_done is
//    ignored in RUN; there is no return to BOOT except via reset.
//  - RUN arbitration: if ld_req and not (fetch_req and burst_cnt==LOAD_BURST_MAX),
//    grant loader; else if fetch_req grant fetch. fetch_stall = fetch_req & !fetch_gnt.
//  - burst_cnt: +1 on loader grant while fetch_req=1; cleared on fetch grant or when
//    fetch_req=0; saturates at LOAD_BURST_MAX, never wraps. Fetch therefore waits at
//    most LOAD_BURST_MAX cycles.
//  - Read latency 1: owner_q <= FETCH/LOADER on a read grant, NONE on a write or idle.
//    Next cycle the matching *_rvalid=1 and *_rdata<=mem_rdata (registered); the other
//    port's rvalid=0 and its rdata holds. Back-to-back grants give 1 word/cycle.
//  - Loader writes produce no rvalid. A read of the same address in the following
//    cycle returns the newly written word (write-first memory).
//  - Reset mid-operation: in-flight read is discarded; no rvalid after reset release.
// STRUCTURE
//  - Package imem_arb_pkg: state encoding (BOOT, RUN), owner encoding
//    (NONE, FETCH, LOADER).
//  - One sub-module: imem_arb_burst_ctr (saturating burst counter, inputs inc/clr,
//    output at_max).
//  - Arbitration and mem mux are combinational; state, owner_q, counter and rdata
//    registers are flopped with async active-low reset.
// TESTING
//  1 Reset, fetch_req=1, no ld_done for 20 cycles -> fetch_stall=1 each cycle, mem_en=0
//    unless ld_req.
//  2 BOOT: loader writes 0x00500093 to addr 0..3, ld_done with last write; then
//    fetch_req addr 0 -> fetch_stall=0, next cycle fetch_rvalid=1, rdata=0x00500093.
//  3 RUN, fetch_req held, ld_req held continuously, LOAD_BURST_MAX=8 -> 8 loader grants,
//    then 1 fetch grant, counter cleared, pattern repeats.
//  4 Loader write addr 5 = 0xDEADBEEF, then fetch read addr 5 next cycle ->
//    fetch_rdata=0xDEADBEEF; ld_rvalid stays 0.
//  5 Alternate loader read (addr 2) and fetch read (addr 3) -> each rvalid on the correct
//    port only, one cycle after its grant, with the other port's rdata held.
//  6 Assert rst during a granted fetch read -> fetch_rvalid=0 after release,
//    state=BOOT, fetch_stall=1.

Source files
------------

// File: rtl/imem_arb_pkg.sv
// Shared encodings for the instruction-memory arbiter.
// Latency: n/a; backpressure: n/a.
package imem_arb_pkg;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE   = 2'd0,
    OWN_FETCH  = 2'd1,
    OWN_LOADER = 2'd2
  } owner_e;

  // Counter width able to hold 0..max inclusive.
  function automatic int unsigned cnt_w(input int unsigned max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/imem_arb_burst_ctr.sv
// Saturating count of consecutive loader grants while fetch is waiting.
// Latency: at_max reflects the registered count; backpressure: none.
module imem_arb_burst_ctr
  import imem_arb_pkg::*;
#(
  parameter int unsigned MAX = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int unsigned W = cnt_w(MAX);
  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != MAX_V)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign at_max = (cnt_q == MAX_V);

endmodule

// File: rtl/imem_arbiter.sv
// Single-port instruction memory shared by fetch and loader; loader-only until ld_done.
// Latency: grant same cycle, read data 1 cycle later; backpressure: fetch_stall / ld_gnt low.
module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned LOAD_BURST_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_stall,
  output logic              fetch_rvalid,
  output logic [DATA_W-1:0] fetch_rdata,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  input  logic              ld_done,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e state_q, state_d;
  owner_e owner_q, owner_d;
  logic   fetch_gnt;
  logic   at_max;

  logic [DATA_W-1:0] fetch_hold_q;
  logic [DATA_W-1:0] ld_hold_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_BOOT;
      owner_q <= OWN_NONE;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  // Combinational outputs are forced idle while reset is asserted.
  always_comb begin
    state_d     = state_q;
    owner_d     = OWN_NONE;
    ld_gnt      = 1'b0;
    fetch_gnt   = 1'b0;
    fetch_stall = 1'b1;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    if (rst) begin
      case (state_q)
        ST_BOOT: begin
          ld_gnt = ld_req;
          if (ld_done) state_d = ST_RUN;
        end
        ST_RUN: begin
          ld_gnt      = ld_req && !(fetch_req && at_max);
          fetch_gnt   = fetch_req && !ld_gnt;
          fetch_stall = fetch_req && !fetch_gnt;
        end
        default: ;
      endcase

      if (ld_gnt) begin
        mem_en    = 1'b1;
        mem_we    = ld_we;
        mem_addr  = ld_addr;
        mem_wdata = ld_wdata;
        owner_d   = ld_we ? OWN_NONE : OWN_LOADER;
      end else if (fetch_gnt) begin
        mem_en   = 1'b1;
        mem_addr = fetch_addr;
        owner_d  = OWN_FETCH;
      end
    end
  end

  imem_arb_burst_ctr #(
    .MAX (LOAD_BURST_MAX)
  ) u_burst_ctr (
    .clk    (clk),
    .rst    (rst),
    .inc    (ld_gnt && fetch_req),
    .clr    (fetch_gnt || !fetch_req),
    .at_max (at_max)
  );

  // The memory output is already a register; the hold flops keep the last word
  // visible on each port while the other port owns the read slot.
  assign fetch_rvalid = (owner_q == OWN_FETCH);
  assign ld_rvalid    = (owner_q == OWN_LOADER);
  assign fetch_rdata  = fetch_rvalid ? mem_rdata : fetch_hold_q;
  assign ld_rdata     = ld_rvalid ? mem_rdata : ld_hold_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_hold_q <= '0;
      ld_hold_q    <= '0;
    end else begin
      if (fetch_rvalid) fetch_hold_q <= mem_rdata;
      if (ld_rvalid)    ld_hold_q    <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a per-cycle reference model and literal spot checks.
module tb_imem_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LBM = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fetch_req = 1'b0;
  logic [AW-1:0] fetch_addr = '0;
  logic          fetch_stall, fetch_rvalid;
  logic [DW-1:0] fetch_rdata;
  logic          ld_req = 1'b0, ld_we = 1'b0, ld_done = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_wdata = '0;
  logic          ld_gnt, ld_rvalid;
  logic [DW-1:0] ld_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  int n_chk  = 0;
  int n_fail = 0;

  imem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .LOAD_BURST_MAX(LBM)
  ) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_stall(fetch_stall),
    .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_done(ld_done), .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk_b(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_w(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Environment: synchronous single-port memory, 64 words, default word = 0xA000_0000 | index.
  logic [31:0] mem [0:63];
  bit          mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hA000_0000 + i;
      mem_init <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr[5:0]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[5:0]];
    end
  end

  // Reference model: boot flag, count of loader wins while fetch waits,
  // pending read per port, last delivered word per port, shadow memory.
  logic [31:0] ref_mem [0:63];
  bit          ref_init = 1'b0;
  bit          m_run = 1'b0, m_pf = 1'b0, m_pl = 1'b0;
  int          m_wait = 0;
  logic [31:0] m_pf_d = '0, m_pl_d = '0, m_f_last = '0, m_l_last = '0;

  bit          n_run = 1'b0, n_pf = 1'b0, n_pl = 1'b0, n_wr = 1'b0;
  int          n_wait = 0;
  logic [31:0] n_pf_d = '0, n_pl_d = '0, n_f_last = '0, n_l_last = '0;
  logic [5:0]  n_wa = '0;
  logic [31:0] n_wd = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      if (!ref_init) begin
        for (int i = 0; i < 64; i++) ref_mem[i] <= 32'hA000_0000 + i;
        ref_init <= 1'b1;
      end
      m_run <= 1'b0; m_wait <= 0; m_pf <= 1'b0; m_pl <= 1'b0;
      m_pf_d <= '0; m_pl_d <= '0; m_f_last <= '0; m_l_last <= '0;
    end else begin
      m_run <= n_run; m_wait <= n_wait; m_pf <= n_pf; m_pl <= n_pl;
      m_pf_d <= n_pf_d; m_pl_d <= n_pl_d; m_f_last <= n_f_last; m_l_last <= n_l_last;
      if (n_wr) ref_mem[n_wa] <= n_wd;
    end
  end

  // Compare process: every falling edge, outputs against the model.
  always @(negedge clk) begin
    bit e_ld, e_f, e_stall;
    if (!rst) begin
      chk_b("rst_fetch_stall", fetch_stall, 1'b1);
      chk_b("rst_ld_gnt", ld_gnt, 1'b0);
      chk_b("rst_mem_en", mem_en, 1'b0);
      chk_b("rst_mem_we", mem_we, 1'b0);
      chk_w("rst_mem_addr", mem_addr, 32'h0);
      chk_w("rst_mem_wdata", mem_wdata, 32'h0);
      chk_b("rst_fetch_rvalid", fetch_rvalid, 1'b0);
      chk_b("rst_ld_rvalid", ld_rvalid, 1'b0);
      chk_w("rst_fetch_rdata", fetch_rdata, 32'h0);
      chk_w("rst_ld_rdata", ld_rdata, 32'h0);
    end else begin
      e_ld    = m_run ? (ld_req && !(fetch_req && m_wait >= LBM)) : ld_req;
      e_f     = m_run && fetch_req && !e_ld;
      e_stall = m_run ? (fetch_req && !e_f) : 1'b1;
      chk_b("ld_gnt", ld_gnt, e_ld);
      chk_b("fetch_stall", fetch_stall, e_stall);
      chk_b("mem_en", mem_en, e_ld || e_f);
      chk_b("mem_we", mem_we, e_ld && ld_we);
      if (e_ld)     chk_w("mem_addr", mem_addr, ld_addr);
      else if (e_f) chk_w("mem_addr", mem_addr, fetch_addr);
      if (e_ld && ld_we) chk_w("mem_wdata", mem_wdata, ld_wdata);
      chk_b("fetch_rvalid", fetch_rvalid, m_pf);
      chk_b("ld_rvalid", ld_rvalid, m_pl);
      chk_w("fetch_rdata", fetch_rdata, m_pf ? m_pf_d : m_f_last);
      chk_w("ld_rdata", ld_rdata, m_pl ? m_pl_d : m_l_last);

      n_run    = m_run || ld_done;
      n_pf     = e_f;
      n_pf_d   = ref_mem[fetch_addr[5:0]];
      n_pl     = e_ld && !ld_we;
      n_pl_d   = ref_mem[ld_addr[5:0]];
      n_f_last = m_pf ? m_pf_d : m_f_last;
      n_l_last = m_pl ? m_pl_d : m_l_last;
      n_wr     = e_ld && ld_we;
      n_wa     = ld_addr[5:0];
      n_wd     = ld_wdata;
      if (!fetch_req || e_f) n_wait = 0;
      else if (e_ld)         n_wait = (m_wait + 1 > LBM) ? LBM : m_wait + 1;
      else                   n_wait = m_wait;
    end
  end

  task automatic set_in(input logic fr, input logic [31:0] fa, input logic lr,
                        input logic lw, input logic [31:0] la, input logic [31:0] lwd,
                        input logic dn);
    fetch_req = fr; fetch_addr = fa;
    ld_req = lr; ld_we = lw; ld_addr = la; ld_wdata = lwd; ld_done = dn;
  endtask

  task automatic idle();
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lg;
    int fg[$];

    #2 rst = 1'b0;
    @(negedge clk);
    chk_b("t0_reset_stall", fetch_stall, 1'b1);
    chk_b("t0_reset_mem_en", mem_en, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;

    // 1: BOOT holds fetch off; memory only touched by loader reads
    for (int i = 0; i < 20; i++) begin
      set_in(1'b1, 32'(i), (i % 4 == 1), 1'b0, 32'(i), 32'h0, 1'b0);
      @(negedge clk);
      chk_b("t1_stall", fetch_stall, 1'b1);
      chk_b("t1_mem_en", mem_en, (i % 4 == 1));
      tick();
    end

    // 2: program load then first fetch
    for (int i = 0; i < 4; i++) begin
      set_in(1'b0, 32'h0, 1'b1, 1'b1, 32'(i), 32'h0050_0093, (i == 3));
      tick();
    end
    set_in(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    chk_b("t2_fetch_granted", fetch_stall, 1'b0);
    tick();
    idle();
    @(negedge clk);
    chk_b("t2_fetch_rvalid", fetch_rvalid, 1'b1);
    chk_w("t2_fetch_rdata", fetch_rdata, 32'h0050_0093);
    tick();

    // 3: both requesting -> 8 loader grants then 1 fetch grant, repeating
    lg = 0;
    set_in(1'b1, 32'd10, 1'b1, 1'b0, 32'd7, 32'h0, 1'b0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ld_gnt) lg++;
      if (!fetch_stall) fg.push_back(c);
      tick();
    end
    chk_i("t3_ld_grants", lg, 18);
    chk_i("t3_fetch_grants", fg.size(), 2);
    chk_i("t3_first_fetch_cycle", (fg.size() > 0) ? fg[0] : -1, 8);
    chk_i("t3_second_fetch_cycle", (fg.size() > 1) ? fg[1] : -1, 17);
    idle();
    tick();

    // 4: write then immediate fetch of the same word
    set_in(1'b0, 32'h0, 1'b1, 1'b1, 32'd5, 32'hDEAD_BEEF, 1'b0);
    tick();
    set_in(1'b1, 32'd5, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    chk_b("t4_fetch_granted", fetch_stall, 1'b0);
    chk_b("t4_no_ld_rvalid_after_write", ld_rvalid, 1'b0);
    tick();
    idle();
    @(negedge clk);
    chk_b("t4_fetch_rvalid", fetch_rvalid, 1'b1);
    chk_w("t4_fetch_rdata", fetch_rdata, 32'hDEAD_BEEF);
    chk_b("t4_ld_rvalid", ld_rvalid, 1'b0);
    tick();

    // 5: alternating loader/fetch reads, each return on its own port only
    set_in(1'b0, 32'h0, 1'b1, 1'b1, 32'd3, 32'h0030_0113, 1'b0);
    tick();
    set_in(1'b0, 32'h0, 1'b1, 1'b0, 32'd2, 32'h0, 1'b0);
    tick();
    set_in(1'b1, 32'd3, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    chk_b("t5a_ld_rvalid", ld_rvalid, 1'b1);
    chk_w("t5a_ld_rdata", ld_rdata, 32'h0050_0093);
    chk_b("t5a_fetch_rvalid", fetch_rvalid, 1'b0);
    chk_w("t5a_fetch_rdata_held", fetch_rdata, 32'hDEAD_BEEF);
    tick();
    set_in(1'b0, 32'h0, 1'b1, 1'b0, 32'd2, 32'h0, 1'b0);
    @(negedge clk);
    chk_b("t5b_fetch_rvalid", fetch_rvalid, 1'b1);
    chk_w("t5b_fetch_rdata", fetch_rdata, 32'h0030_0113);
    chk_b("t5b_ld_rvalid", ld_rvalid, 1'b0);
    chk_w("t5b_ld_rdata_held", ld_rdata, 32'h0050_0093);
    tick();
    idle();
    @(negedge clk);
    chk_b("t5c_ld_rvalid", ld_rvalid, 1'b1);
    chk_b("t5c_fetch_rvalid", fetch_rvalid, 1'b0);
    chk_w("t5c_fetch_rdata_held", fetch_rdata, 32'h0030_0113);
    tick();

    // 6: reset lands on a granted fetch read
    set_in(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    chk_b("t6_fetch_granted", fetch_stall, 1'b0);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_b("t6_in_reset_rvalid", fetch_rvalid, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    set_in(1'b1, 32'h0, 1'b1, 1'b0, 32'd1, 32'h0, 1'b0);
    @(negedge clk);
    chk_b("t6_post_rvalid", fetch_rvalid, 1'b0);
    chk_b("t6_post_stall_boot", fetch_stall, 1'b1);
    chk_b("t6_post_ld_gnt_boot", ld_gnt, 1'b1);
    tick();
    idle();
    @(negedge clk);
    chk_b("t6_post_rvalid2", fetch_rvalid, 1'b0);
    chk_b("t6_ld_rvalid", ld_rvalid, 1'b1);
    chk_w("t6_ld_rdata", ld_rdata, 32'h0050_0093);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
